// File: rtl/uart_tx_sched.sv
// Transmit scheduler sharing one uart_tx between the loopback FIFO and a status source.
// Optional SEND watchdog enabled by defining UART_TX_SCHED_WATCHDOG_EN.
module uart_tx_sched #(
  parameter int unsigned HOLDOFF_CYCLES = 266000000,
  parameter int unsigned GAP_CYCLES     = 1155,
  parameter int unsigned WDOG_CYCLES    = 16384
) (
  input  logic       osc_clk,
  input  logic       Reset,
  input  logic       fifo_empty,
  output logic       fifo_rden,
  input  logic [7:0] fifo_q,
  input  logic       stat_req,
  input  logic [7:0] stat_byte,
  output logic       stat_ack,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       busy,
  output logic       grant_src,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, FRD, FCAP, SACK, LOAD, SEND, GAP} state_t;

  state_t      state;
  logic [31:0] hold_cnt;
  logic [31:0] gap_cnt;
  logic        last_grant;
  logic        fifo_elig;

  assign fifo_elig = !fifo_empty && (hold_cnt == HOLDOFF_CYCLES);

  // Hold-off restarts only when the FIFO actually drains.
  always_ff @(posedge osc_clk) begin
    if (Reset || fifo_empty) hold_cnt <= '0;
    else if (hold_cnt != HOLDOFF_CYCLES) hold_cnt <= hold_cnt + 32'd1;
  end

`ifdef UART_TX_SCHED_WATCHDOG_EN
  logic [31:0] wdog_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge osc_clk) begin
    if (Reset) begin
      state      <= IDLE;
      fifo_rden  <= 1'b0;
      stat_ack   <= 1'b0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      busy       <= 1'b0;
      grant_src  <= 1'b0;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
`ifdef UART_TX_SCHED_WATCHDOG_EN
      wdog_cnt   <= '0;
      err        <= 1'b0;
`endif
    end else begin
      fifo_rden <= 1'b0;
      stat_ack  <= 1'b0;
      tx_dv     <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_active && (fifo_elig || stat_req)) begin
            busy <= 1'b1;
            // Strobes are raised on the grant edge so they are visible in FRD/SACK.
            if (fifo_elig && (!stat_req || last_grant)) begin
              state      <= FRD;
              fifo_rden  <= 1'b1;
              grant_src  <= 1'b0;
              last_grant <= 1'b0;
            end else begin
              state      <= SACK;
              stat_ack   <= 1'b1;
              grant_src  <= 1'b1;
              last_grant <= 1'b1;
            end
          end
        end
        FRD: state <= FCAP;
        FCAP: begin
          tx_byte <= fifo_q;
          tx_dv   <= 1'b1;
          state   <= LOAD;
        end
        SACK: begin
          tx_byte <= stat_byte;
          tx_dv   <= 1'b1;
          state   <= LOAD;
        end
        LOAD: begin
          state <= SEND;
`ifdef UART_TX_SCHED_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
        end
        SEND: begin
          if (tx_done) begin
            gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
`ifdef UART_TX_SCHED_WATCHDOG_EN
          else if (wdog_cnt + 32'd1 >= WDOG_CYCLES) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_CYCLES - 1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: hold-off, round-robin, gap, reset in SEND, watchdog.
module tb_uart_tx_sched;

  logic       osc_clk = 1'b0;
  logic       Reset;
  logic       fifo_empty;
  logic       fifo_rden;
  logic [7:0] fifo_q;
  logic       stat_req;
  logic [7:0] stat_byte;
  logic       stat_ack;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic       busy;
  logic       grant_src;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_sched #(
    .HOLDOFF_CYCLES(10),
    .GAP_CYCLES    (5),
    .WDOG_CYCLES   (100)
  ) dut (
    .osc_clk   (osc_clk),
    .Reset     (Reset),
    .fifo_empty(fifo_empty),
    .fifo_rden (fifo_rden),
    .fifo_q    (fifo_q),
    .stat_req  (stat_req),
    .stat_byte (stat_byte),
    .stat_ack  (stat_ack),
    .tx_dv     (tx_dv),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_src (grant_src),
    .err       (err)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(input string tag, output int n);
    n = 0;
    while (tx_dv !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check(tag, {31'd0, tx_dv}, 32'd1);
  endtask

  // Stand-in for uart_tx: short frame, then a one-cycle done pulse.
  task automatic send_frame();
    tx_active = 1'b1;
    repeat (3) tick();
    tx_done   = 1'b1;
    tx_active = 1'b0;
    tick();
    tx_done   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rden"},  {31'd0, fifo_rden}, 32'd0);
    check({tag, "_ack"},   {31'd0, stat_ack},  32'd0);
    check({tag, "_dv"},    {31'd0, tx_dv},     32'd0);
    check({tag, "_byte"},  {24'd0, tx_byte},   32'h00);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_gsrc"},  {31'd0, grant_src}, 32'd0);
    check({tag, "_err"},   {31'd0, err},       32'd0);
  endtask

  initial begin
    int n;
    int seen;
    Reset = 1'b1; fifo_empty = 1'b1; fifo_q = 8'h00; stat_req = 1'b0;
    stat_byte = 8'h00; tx_active = 1'b0; tx_done = 1'b0;
    tick(); tick();
    check_reset_vals("reset");

    // Hold-off: rden 11 cycles after fifo_empty falls, tx_dv 2 cycles later
    Reset = 1'b0; fifo_empty = 1'b0; fifo_q = 8'h41;
    n = 0;
    while (fifo_rden !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("holdoff_rden_delay", n, 32'd11);
    wait_dv("holdoff_dv_seen", n);
    check("holdoff_dv_delay", n, 32'd2);
    check("holdoff_byte", {24'd0, tx_byte}, 32'h41);
    check("holdoff_gsrc", {31'd0, grant_src}, 32'd0);
    fifo_empty = 1'b1;
    send_frame();

    // Round-robin: both eligible after reset -> FIFO, status, FIFO
    Reset = 1'b1; tx_active = 1'b1; fifo_empty = 1'b0; fifo_q = 8'h31;
    stat_req = 1'b1; stat_byte = 8'hA5;
    tick();
    Reset = 1'b0;
    repeat (12) tick();
    tx_active = 1'b0;
    wait_dv("rr0_dv", n);
    check("rr0_byte", {24'd0, tx_byte}, 32'h31);
    check("rr0_gsrc", {31'd0, grant_src}, 32'd0);
    fifo_q = 8'h32;
    send_frame();
    wait_dv("rr1_dv", n);
    check("rr1_byte", {24'd0, tx_byte}, 32'hA5);
    check("rr1_gsrc", {31'd0, grant_src}, 32'd1);
    stat_req = 1'b0;
    send_frame();
    wait_dv("rr2_dv", n);
    check("rr2_byte", {24'd0, tx_byte}, 32'h32);
    check("rr2_gsrc", {31'd0, grant_src}, 32'd0);
    fifo_empty = 1'b1;
    send_frame();

    // Gap: next stat_ack exactly 7 cycles after tx_done
    stat_req = 1'b1; stat_byte = 8'h5A;
    wait_dv("gap_first_dv", n);
    check("gap_first_byte", {24'd0, tx_byte}, 32'h5A);
    tx_active = 1'b1;
    tick(); tick();
    check("send_byte_stable", {24'd0, tx_byte}, 32'h5A);
    tx_done = 1'b1; tx_active = 1'b0;
    n = 0;
    do begin
      tick();
      tx_done = 1'b0;
      n++;
    end while (stat_ack !== 1'b1 && n < 30);
    check("gap_ack_delay", n, 32'd7);
    wait_dv("gap_second_dv", n);
    check("gap_second_byte", {24'd0, tx_byte}, 32'h5A);

    // Reset while SEND with uart_tx still active
    stat_byte = 8'h77; tx_active = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset_vals("rst_send");
    seen = 0;
    repeat (4) begin
      tick();
      if (stat_ack === 1'b1 || busy === 1'b1) seen++;
    end
    check("rst_send_no_grant", seen, 32'd0);
    tx_active = 1'b0;
    tick();
    check("rst_send_regrant_ack", {31'd0, stat_ack}, 32'd1);
    check("rst_send_regrant_gsrc", {31'd0, grant_src}, 32'd1);

    // Watchdog: tx_done never arrives
    wait_dv("wdog_dv", n);
    stat_req = 1'b0; tx_active = 1'b1;
    repeat (50) tick();
    check("wdog_early_err", {31'd0, err}, 32'd0);
    check("wdog_early_busy", {31'd0, busy}, 32'd1);
    repeat (60) tick();
`ifdef UART_TX_SCHED_WATCHDOG_EN
    check("wdog_err", {31'd0, err}, 32'd1);
    check("wdog_busy", {31'd0, busy}, 32'd0);
`else
    check("nowdog_err", {31'd0, err}, 32'd0);
    check("nowdog_busy", {31'd0, busy}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler that owns the single `uart_tx` instance and shares it between two byte sources: the loopback FIFO (echo path) and a status/telemetry requester. It replaces the free-running one-shot delay counter in the top level. It does four things:
- applies a programmable hold-off before the FIFO is drained;
- arbitrates round-robin between the FIFO and status sources;
- sequences the FIFO read-enable, byte capture and `i_Tx_DV` pulse;
- enforces an idle gap between bytes.

## Interface
Parameters:
- `HOLDOFF_CYCLES`, 266000000: consecutive non-empty cycles required before the FIFO source becomes eligible; 0 = immediate.
- `GAP_CYCLES`, 1155: idle cycles inserted after each `tx_done` (one bit time at 1155 clks/bit); 0 = no gap.
- `WDOG_CYCLES`, 16384: watchdog limit in SEND (used only with the watchdog macro).

Ports:
- `osc_clk` in 1: the only clock.
- `Reset` in 1: synchronous, active-high.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rden` out 1: FIFO read enable, one-cycle pulse.
- `fifo_q` in 8: FIFO read data, valid the cycle after `fifo_rden`.
- `stat_req` in 1: status source request level.
- `stat_byte` in 8: status byte, valid while `stat_req` is high.
- `stat_ack` out 1: one-cycle pulse; `stat_byte` is captured this cycle.
- `tx_dv` out 1: to `uart_tx` `i_Tx_DV`, one-cycle pulse.
- `tx_byte` out 8: to `uart_tx` `i_Tx_Byte`, registered.
- `tx_active` in 1: from `uart_tx` `o_Tx_Active`.
- `tx_done` in 1: from `uart_tx` `o_Tx_Done`, one-cycle pulse.
- `busy` out 1: high in every state except IDLE.
- `grant_src` out 1: source of the current or last byte; 0 = FIFO, 1 = status.
- `err` out 1: sticky watchdog flag.

## Operation
- **Reset values:** `fifo_rden`=0, `stat_ack`=0, `tx_dv`=0, `tx_byte`=0x00, `busy`=0, `grant_src`=0, `err`=0, hold-off counter=0, `last_grant`=1, state=IDLE.
- **Hold-off counter (32 bit):**
  - Clears whenever `fifo_empty`=1.
  - Otherwise increments, saturating at `HOLDOFF_CYCLES`.
  - `fifo_elig` = !`fifo_empty` && counter == `HOLDOFF_CYCLES`.
- **States:**
  - **IDLE:** evaluated only when `tx_active`=0.
    - Both sources eligible: grant the source not equal to `last_grant`.
    - Single eligible source: grant it.
    - FIFO granted → FRD. Status granted → SACK.
  - **FRD:** `fifo_rden`=1 → FCAP.
  - **FCAP:** `tx_byte` <= `fifo_q` → LOAD.
  - **SACK:** `stat_ack`=1, `tx_byte` <= `stat_byte` → LOAD.
  - **LOAD:** `tx_dv`=1 → SEND.
  - **SEND:** hold `tx_byte` stable. On `tx_done`=1, go to GAP (or to IDLE if `GAP_CYCLES`=0).
  - **GAP:** count `GAP_CYCLES`, then IDLE.
- `last_grant` and `grant_src` update on the grant cycle.
- **Boundary conditions:**
  - `tx_done` outside SEND is ignored.
  - `stat_req` must stay high until `stat_ack`. Once granted, the ack is issued and the byte sent regardless of `stat_req`.
  - `fifo_empty` rising after a FIFO grant cannot occur, because this block is the sole reader. The hold-off counter clears only if the FIFO actually empties.
  - Hold-off is applied per empty→non-empty episode. While the FIFO stays non-empty, back-to-back FIFO bytes see no further hold-off.
  - **Reset mid-operation:** state returns to IDLE on the next edge and all outputs take their reset values. A byte already in flight in `uart_tx` is not aborted; IDLE waits for `tx_active`=0 before any new grant.

## Timing
- **FIFO path:** grant at cycle N (IDLE) → `fifo_rden` at N+1 → capture at N+2 → `tx_dv` at N+3.
- **Status path:** grant at N → `stat_ack` and capture at N+1 → `tx_dv` at N+2.
- `tx_byte` is stable from the `tx_dv` cycle through `tx_done`.
- Minimum byte-to-byte spacing is the `uart_tx` frame time + `GAP_CYCLES` + 1 (IDLE) + path latency.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: `UART_TX_SCHED_WATCHDOG_EN`.
- **Defined:** a counter runs in SEND. If it reaches `WDOG_CYCLES` without `tx_done`, the block sets `err`=1 (sticky until `Reset`) and returns to IDLE. `last_grant` is preserved and the byte is dropped.
- **Undefined:** no counter is built, `err` is tied 0, and SEND waits indefinitely.

## Test plan
- **Hold-off:** `HOLDOFF_CYCLES`=10, write 0x41 to the FIFO → `fifo_rden` fires exactly 10 cycles after `fifo_empty` falls, +1; `tx_dv` fires 2 cycles later with `tx_byte`=0x41.
- **Round-robin:** FIFO holds 0x31, 0x32 and `stat_req` is held with 0xA5 → transmit order 0x31, 0xA5, 0x32; `grant_src` = 0, 1, 0.
- **Gap:** `GAP_CYCLES`=5 with back-to-back status bytes → the next `stat_ack` comes exactly 7 cycles after `tx_done` (5 GAP + 1 IDLE + 1).
- **Reset in SEND:** pulse `Reset` while `tx_active`=1 → all outputs reach reset values the next cycle, and there is no new grant until `tx_active`=0.
- **Watchdog (macro defined, `WDOG_CYCLES`=100):** suppress `tx_done` → `err`=1 at cycle 100 of SEND, `busy`=0 the next cycle.
- **Watchdog absent (macro undefined):** same stimulus → `busy` stays 1 and `err`=0.
